dmem_scratchpad: RTL and testbench
==================================

# dmem_scratchpad

Single-ported data scratchpad serving the LSU memory interface (mem_req/mem_we/mem_addr/mem_wdata → mem_ready/mem_rdata/mem_error). It sits directly downstream of the LSU.
- One access in flight; fixed, parameterised latency; one-cycle completion pulse.
- Bounds and alignment are checked on every access.
- A side port preloads the array from the bench or boot logic, and two counters expose traffic statistics.

## Interface
- XLEN, 32, data/address width
- DEPTH_WORDS, 1024, array size in 32-bit words (power of two)
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (DEPTH_WORDS*4-aligned)
- LATENCY, 2, cycles from accept to mem_ready (legal 1..15)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- mem_req  in  1  request valid, held until mem_ready seen
- mem_we  in  1  1=write, 0=read
- mem_addr  in  XLEN  byte address
- mem_wdata  in  XLEN  write data
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  XLEN  read data, valid with mem_ready
- mem_error  out  1  access fault, valid with mem_ready
- init_we  in  1  preload write strobe
- init_addr  in  $clog2(DEPTH_WORDS)  preload word index
- init_wdata  in  XLEN  preload data
- access_count  out  32  completed non-error accesses, wraps
- error_count  out  16  faulted accesses, saturates at 16'hFFFF

## Operation
- FSM states:
  - IDLE: on mem_req=1, latch we/addr/wdata, evaluate fault, load counter with LATENCY-1. Go to BUSY; if LATENCY=1, go directly to RESP.
  - BUSY: decrement the counter; at 0 go to RESP.
  - RESP: mem_ready=1 for exactly this cycle, then return to IDLE.
- Fault: addr[1:0]≠0, or addr outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4). This covers the 0xF000_0000 MMIO space.
  - Faulted access: mem_error=1, mem_rdata=0, no array write, error_count+1.
- Word index = (addr-BASE_ADDR)[$clog2(DEPTH_WORDS)+1:2].
- Read: array is read so that data reflects all writes committed before the RESP cycle; mem_rdata is registered.
  - mem_rdata holds its last value outside RESP (not cleared). On a faulted read it becomes 0.
- Write: array is updated at the clock edge ending the RESP cycle. mem_rdata is unchanged by writes.
- access_count increments at the end of a non-fault RESP; error_count at the end of a faulted RESP.
- Init port: writes the array on any cycle with init_we=1, regardless of FSM state.
  - Same-edge collision with a core write to the same word: the core write wins.
- mem_req in RESP is ignored; the LSU deasserts it only at the edge where it samples mem_ready.

## Timing
- Reset values: mem_ready=0, mem_error=0, mem_rdata=0, access_count=0, error_count=0, state IDLE. Array contents are not reset.
- Accept at cycle T (IDLE, mem_req=1) → mem_ready at T+LATENCY.
- Earliest next accept is T+LATENCY+1, giving throughput of one access per LATENCY+1 cycles.
- mem_we/mem_addr/mem_wdata changes after accept have no effect.
- Reset asserted in any cycle including RESP: FSM returns to IDLE and outputs go to their reset values. An uncommitted write is dropped; reset has priority over the RESP-edge write.
- mem_error and mem_ready are never asserted outside RESP.

## Structure
- core_pkg gains:
  - sp_state_t (IDLE, BUSY, RESP)
  - SP_FAULT_MISALIGN / SP_FAULT_RANGE localparams for future cause reporting
- Sub-module sp_ram: DEPTH_WORDS×XLEN synchronous single-read, dual-write-port array (core port, init port) with core-wins priority.
- FSM, fault check and counters live in dmem_scratchpad.

## Test plan
- Preload word 4 = 32'hCAFE_F00D via init port; read 0x10 with LATENCY=2, accepted at T → mem_ready at T+2, mem_rdata=32'hCAFE_F00D, mem_error=0, access_count=1.
- Write 32'h1234_5678 to 0x20, then read 0x20 at the earliest legal cycle → mem_rdata=32'h1234_5678.
  - Hold mem_req high through RESP → no second accept.
- Read 0x22 → mem_error=1, mem_rdata=0, error_count=1. Write 0xF000_0000 → mem_error=1 and array unchanged (verify by reading 0x0).
- LATENCY=1: back-to-back reads of 0x0 and 0x4 → mem_ready pulses two cycles apart.
- Assert reset during the RESP cycle of a write of 32'hFFFF_FFFF to 0x8 → after reset, read 0x8 returns the prior value. mem_ready stays 0 during reset.
- Same-cycle init_we and core write commit to word 3 with different data → the core data is read back.

Source files
------------

// File: rtl/dmem_scratchpad_pkg.sv
// Shared types and constants for the LSU data scratchpad.
// Fault cause codes are reserved here so a later cause register can reuse them.
package dmem_scratchpad_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } sp_state_t;

    localparam logic [1:0] SP_FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] SP_FAULT_RANGE    = 2'b10;

    localparam int SP_CNT_W = 4;

endpackage

// File: rtl/dmem_scratchpad_sp_ram.sv
// Scratchpad storage: one synchronous read port, core and init write ports.
// A core write and an init write to the same word on one edge keep the core data.
module sp_ram
    import dmem_scratchpad_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_rd_en,
    input  logic            i_rd_zero,
    input  logic [AW-1:0]   i_rd_idx,
    output logic [XLEN-1:0] o_rd_data,
    input  logic            i_core_we,
    input  logic [AW-1:0]   i_core_idx,
    input  logic [XLEN-1:0] i_core_wdata,
    input  logic            i_init_we,
    input  logic [AW-1:0]   i_init_idx,
    input  logic [XLEN-1:0] i_init_wdata
);

    logic [XLEN-1:0] r_mem [DEPTH_WORDS];
    logic [XLEN-1:0] r_rd_data;
    logic            w_init_ok;

    assign w_init_ok = i_init_we && !(i_core_we && (i_core_idx == i_init_idx));

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (i_core_we)
            r_mem[i_core_idx] <= i_core_wdata;
        if (w_init_ok)
            r_mem[i_init_idx] <= i_init_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_rd_data <= '0;
        else if (i_rd_en)
            r_rd_data <= i_rd_zero ? '0 : r_mem[i_rd_idx];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dmem_scratchpad.sv
// Single-ported LSU data scratchpad: fixed-latency FSM, bounds/alignment fault
// check, preload side port and access/error statistics.
module dmem_scratchpad
    import dmem_scratchpad_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              DEPTH_WORDS = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR   = '0,
    parameter int              LATENCY     = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           mem_req,
    input  logic                           mem_we,
    input  logic [XLEN-1:0]                mem_addr,
    input  logic [XLEN-1:0]                mem_wdata,
    output logic                           mem_ready,
    output logic [XLEN-1:0]                mem_rdata,
    output logic                           mem_error,
    input  logic                           init_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] init_addr,
    input  logic [XLEN-1:0]                init_wdata,
    output logic [31:0]                    access_count,
    output logic [15:0]                    error_count
);

    localparam int              AW   = $clog2(DEPTH_WORDS);
    localparam logic [XLEN-1:0] SPAN = XLEN'(DEPTH_WORDS * 4);

    sp_state_t             r_state, w_state_nxt;
    logic [SP_CNT_W-1:0]   r_cnt;
    logic                  r_we, r_fault;
    logic [AW-1:0]         r_idx;
    logic [XLEN-1:0]       r_wdata;
    logic [31:0]           r_access_count;
    logic [15:0]           r_error_count;

    logic [XLEN-1:0]       w_off;
    logic [1:0]            w_cause;
    logic                  w_accept, w_enter_resp;
    logic                  w_cur_we, w_cur_fault;
    logic [AW-1:0]         w_cur_idx;
    logic                  w_rd_en, w_core_we;

    assign w_off    = mem_addr - BASE_ADDR;
    assign w_cause  = ((mem_addr[1:0] != 2'b00) ? SP_FAULT_MISALIGN : 2'b00)
                    | (((mem_addr < BASE_ADDR) || (w_off >= SPAN)) ? SP_FAULT_RANGE : 2'b00);
    assign w_accept = (r_state == IDLE) && mem_req;

    // With LATENCY=1 the read happens on the accept edge, before the latches hold the request.
    assign w_cur_we    = w_accept ? mem_we           : r_we;
    assign w_cur_fault = w_accept ? (w_cause != 2'b00) : r_fault;
    assign w_cur_idx   = w_accept ? w_off[AW+1:2]    : r_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_fault <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt   <= SP_CNT_W'(LATENCY - 1);
                r_we    <= mem_we;
                r_fault <= (w_cause != 2'b00);
                r_idx   <= w_off[AW+1:2];
                r_wdata <= mem_wdata;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (mem_req) w_state_nxt = (LATENCY == 1) ? RESP : BUSY;
            BUSY:    if (r_cnt == SP_CNT_W'(1)) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_ready    = (r_state == RESP) && !reset;
        mem_error    = (r_state == RESP) && !reset && r_fault;
        w_enter_resp = (w_state_nxt == RESP) && (r_state != RESP) && !reset;
        w_rd_en      = w_enter_resp && !w_cur_we;
        w_core_we    = (r_state == RESP) && !reset && r_we && !r_fault;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_access_count <= '0;
            r_error_count  <= '0;
        end else if (r_state == RESP) begin
            if (!r_fault)
                r_access_count <= r_access_count + 32'd1;
            else if (r_error_count != 16'hFFFF)
                r_error_count <= r_error_count + 16'd1;
        end
    end

    assign access_count = r_access_count;
    assign error_count  = r_error_count;

    sp_ram #(
        .XLEN        (XLEN),
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk          (clk),
        .reset        (reset),
        .i_rd_en      (w_rd_en),
        .i_rd_zero    (w_cur_fault),
        .i_rd_idx     (w_cur_idx),
        .o_rd_data    (mem_rdata),
        .i_core_we    (w_core_we),
        .i_core_idx   (r_idx),
        .i_core_wdata (r_wdata),
        .i_init_we    (init_we),
        .i_init_idx   (init_addr),
        .i_init_wdata (init_wdata)
    );

endmodule

// File: tb/tb_dmem_scratchpad.sv
// Directed bench for dmem_scratchpad: a LATENCY=2 instance for most scenarios
// and a small LATENCY=1 instance for back-to-back throughput.
module tb_dmem_scratchpad;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        mem_req = 1'b0, mem_we = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic        mem_ready, mem_error;
    logic [31:0] mem_rdata;
    logic        init_we = 1'b0;
    logic [9:0]  init_addr = '0;
    logic [31:0] init_wdata = '0;
    logic [31:0] access_count;
    logic [15:0] error_count;

    logic        b_req = 1'b0, b_we = 1'b0;
    logic [31:0] b_addr = '0, b_wdata = '0;
    logic        b_ready, b_error;
    logic [31:0] b_rdata;
    logic        b_init_we = 1'b0;
    logic [3:0]  b_init_addr = '0;
    logic [31:0] b_init_wdata = '0;
    logic [31:0] b_access_count;
    logic [15:0] b_error_count;

    int checks = 0;
    int errors = 0;

    dmem_scratchpad #(.XLEN(32), .DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_error(mem_error),
        .init_we(init_we), .init_addr(init_addr), .init_wdata(init_wdata),
        .access_count(access_count), .error_count(error_count)
    );

    dmem_scratchpad #(.XLEN(32), .DEPTH_WORDS(16), .BASE_ADDR(32'h0), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .mem_req(b_req), .mem_we(b_we), .mem_addr(b_addr),
        .mem_wdata(b_wdata), .mem_ready(b_ready), .mem_rdata(b_rdata), .mem_error(b_error),
        .init_we(b_init_we), .init_addr(b_init_addr), .init_wdata(b_init_wdata),
        .access_count(b_access_count), .error_count(b_error_count)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic preload(input logic [9:0] idx, input logic [31:0] d);
        init_we = 1'b1; init_addr = idx; init_wdata = d;
        @(posedge clk); #1;
        init_we = 1'b0;
    endtask

    // Issues one access from #1 after an edge; returns #1 after the edge that ends RESP.
    // Request fields are scrambled after the accept edge; mem_req stays high through RESP.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic coll, input logic [31:0] cd,
                          output logic [31:0] rd, output logic er, output int lat);
        mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wd;
        lat = 0; rd = '0; er = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                mem_we = ~we; mem_addr = addr ^ 32'h4; mem_wdata = ~wd;
            end
            if (mem_ready) begin
                lat = n;
                break;
            end
        end
        rd = mem_rdata; er = mem_error;
        if (coll) begin
            init_we = 1'b1; init_addr = addr[11:2]; init_wdata = cd;
        end
        @(posedge clk); #1;
        mem_req = 1'b0; init_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", mem_ready); end
        checks++; if (mem_error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b want 0", mem_error); end
        checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", mem_rdata); end
        checks++; if (access_count !== 32'h0) begin errors++; $display("FAIL rst_acc: got %0d want 0", access_count); end
        checks++; if (error_count !== 16'h0) begin errors++; $display("FAIL rst_err: got %0d want 0", error_count); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_read();
        logic [31:0] rd; logic er; int lat;
        preload(10'd4, 32'hCAFE_F00D);
        access(1'b0, 32'h10, 32'h0, 1'b0, 32'h0, rd, er, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL read_latency: got %0d want 2", lat); end
        checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL read_data: got %h want cafef00d", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL read_error: got %b want 0", er); end
        checks++; if (access_count !== 32'd1) begin errors++; $display("FAIL read_acc: got %0d want 1", access_count); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL read_pulse: got %b want 0 after RESP", mem_ready); end
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er; int lat; int pulses;
        access(1'b1, 32'h20, 32'h1234_5678, 1'b0, 32'h0, rd, er, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", lat); end
        checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL wr_rdata_hold: got %h want cafef00d", rd); end
        access(1'b0, 32'h20, 32'h0, 1'b0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL wr_readback: got %h want 12345678", rd); end
        pulses = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (mem_ready) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL hold_no_reaccept: got %0d pulses want 0", pulses); end
        checks++; if (access_count !== 32'd3) begin errors++; $display("FAIL wr_acc: got %0d want 3", access_count); end
    endtask

    task automatic test_fault();
        logic [31:0] rd; logic er; int lat;
        preload(10'd0, 32'h0BAD_0000);
        access(1'b0, 32'h22, 32'h0, 1'b0, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL misalign_err: got %b want 1", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL misalign_rdata: got %h want 0", rd); end
        checks++; if (error_count !== 16'd1) begin errors++; $display("FAIL misalign_cnt: got %0d want 1", error_count); end
        access(1'b1, 32'hF000_0000, 32'h5555_5555, 1'b0, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL mmio_err: got %b want 1", er); end
        checks++; if (error_count !== 16'd2) begin errors++; $display("FAIL mmio_cnt: got %0d want 2", error_count); end
        access(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h0BAD_0000) begin errors++; $display("FAIL mmio_nowrite: got %h want 0bad0000", rd); end
        preload(10'd1023, 32'h0000_3FFC);
        access(1'b0, 32'hFFC, 32'h0, 1'b0, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== 32'h0000_3FFC) begin errors++; $display("FAIL top_word: got err=%b %h want err=0 00003ffc", er, rd); end
        access(1'b0, 32'h1000, 32'h0, 1'b0, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL past_end: got err=%b %h want err=1 0", er, rd); end
        checks++; if (error_count !== 16'd3 || access_count !== 32'd5) begin errors++; $display("FAIL fault_cnts: got err=%0d acc=%0d want 3 5", error_count, access_count); end
    endtask

    task automatic test_collision();
        logic [31:0] rd; logic er; int lat;
        access(1'b1, 32'hC, 32'h1111_1111, 1'b1, 32'h2222_2222, rd, er, lat);
        access(1'b0, 32'hC, 32'h0, 1'b0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL collision: got %h want 11111111", rd); end
    endtask

    task automatic test_reset_in_resp();
        logic [31:0] rd; logic er; int lat;
        preload(10'd2, 32'hA5A5_0008);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h8; mem_wdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL rr_in_resp: got %b want 1", mem_ready); end
        reset = 1'b1;
        #1;
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rr_ready_in_reset: got %b want 0", mem_ready); end
        @(posedge clk); #1;
        mem_req = 1'b0;
        checks++; if (mem_ready !== 1'b0 || access_count !== 32'd0 || error_count !== 16'd0)
            begin errors++; $display("FAIL rr_after: got rdy=%b acc=%0d err=%0d want 0 0 0", mem_ready, access_count, error_count); end
        @(posedge clk); #1;
        reset = 1'b0;
        access(1'b0, 32'h8, 32'h0, 1'b0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hA5A5_0008) begin errors++; $display("FAIL rr_dropped_write: got %h want a5a50008", rd); end
        checks++; if (access_count !== 32'd1) begin errors++; $display("FAIL rr_acc: got %0d want 1", access_count); end
    endtask

    task automatic test_back_to_back();
        int t1, t2; logic [31:0] r1, r2;
        t1 = 0; t2 = 0; r1 = '0; r2 = '0;
        b_init_we = 1'b1; b_init_addr = 4'd0; b_init_wdata = 32'h0000_00A0;
        @(posedge clk); #1;
        b_init_addr = 4'd1; b_init_wdata = 32'h0000_00A4;
        @(posedge clk); #1;
        b_init_we = 1'b0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (b_ready) begin
                if (t1 == 0) begin t1 = c; r1 = b_rdata; b_addr = 32'h4; end
                else if (t2 == 0) begin t2 = c; r2 = b_rdata; end
            end
        end
        b_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (t1 !== 1) begin errors++; $display("FAIL b2b_first: got cycle %0d want 1", t1); end
        checks++; if (t2 - t1 !== 2) begin errors++; $display("FAIL b2b_spacing: got %0d want 2", t2 - t1); end
        checks++; if (r1 !== 32'h0000_00A0 || r2 !== 32'h0000_00A4) begin errors++; $display("FAIL b2b_data: got %h %h want 000000a0 000000a4", r1, r2); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_read();
        test_fault();
        test_collision();
        test_reset_in_resp();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
